// File: rtl/wb_regfile_scoreboard.sv
// Write-back side of the register file: 32x32 architectural registers with write-through reads,
// plus a per-register pending-write scoreboard that tells ID when to stall.
module wb_regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int PEND_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_regwrite,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] write_register,
  input  logic [DATA_W-1:0] write_data,
  input  logic              flush,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              stall,
  output logic              sb_error
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [PEND_W-1:0] r_pend [NUM_REGS];
  logic              r_sb_error;

  logic              w_inc;
  logic              w_dec;
  logic              w_dec_rs;
  logic              w_dec_rt;
  logic [PEND_W-1:0] w_eff_rs;
  logic [PEND_W-1:0] w_eff_rt;
  logic              w_sat;

  assign w_dec    = RegWrite && (write_register != '0);
  assign w_inc    = issue_valid && issue_regwrite && (issue_dest != '0) && !stall && !flush;
  assign w_dec_rs = w_dec && (write_register == rs);
  assign w_dec_rt = w_dec && (write_register == rt);

  // A source being committed this cycle is covered by the write-through path.
  assign w_eff_rs = r_pend[rs] - PEND_W'(w_dec_rs);
  assign w_eff_rt = r_pend[rt] - PEND_W'(w_dec_rt);
  assign w_sat    = issue_regwrite && (issue_dest != '0) && (r_pend[issue_dest] == PEND_MAX);

  assign stall = issue_valid && !flush &&
                 (((rs != '0) && (w_eff_rs != '0)) ||
                  ((rt != '0) && (w_eff_rt != '0)) ||
                  w_sat);

  assign read_data1 = (rs == '0) ? '0 : (w_dec_rs ? write_data : r_regs[rs]);
  assign read_data2 = (rt == '0) ? '0 : (w_dec_rt ? write_data : r_regs[rt]);
  assign sb_error   = r_sb_error;

  // NOTE: the register array is reset because the architectural state must read 0 after reset;
  // a reset-less array would map to RAM but would expose stale values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_dec) begin
      // NOTE: sequential state uses non-blocking assignments so every process sees pre-edge values.
      r_regs[write_register] <= write_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_pend[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) r_pend[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_inc && (issue_dest == ADDR_W'(i)) && !(w_dec && (write_register == ADDR_W'(i)))) begin
          r_pend[i] <= r_pend[i] + 1'b1;
        end else if (w_dec && (write_register == ADDR_W'(i)) && !(w_inc && (issue_dest == ADDR_W'(i)))
                     && (r_pend[i] != '0)) begin
          r_pend[i] <= r_pend[i] - 1'b1;
        end
      end
    end
  end

  // Sticky: a commit with nothing pending means WB and ID disagree about the in-flight set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_error <= 1'b0;
    end else if (!flush && w_dec && (r_pend[write_register] == '0)) begin
      r_sb_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed bench for wb_regfile_scoreboard: expected outputs are queued when each step is driven
// and popped against the DUT one time unit later, away from the clock edge.
module tb_wb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_regwrite;
  logic [4:0]  issue_dest;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        RegWrite;
  logic [4:0]  write_register;
  logic [31:0] write_data;
  logic        flush;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        stall;
  logic        sb_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        st;
    logic        sbe;
  } exp_t;

  exp_t exp_q[$];

  wb_regfile_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_regwrite (issue_regwrite),
    .issue_dest     (issue_dest),
    .rs             (rs),
    .rt             (rt),
    .RegWrite       (RegWrite),
    .write_register (write_register),
    .write_data     (write_data),
    .flush          (flush),
    .read_data1     (read_data1),
    .read_data2     (read_data2),
    .stall          (stall),
    .sb_error       (sb_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cmp1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic irw, input logic [4:0] idest,
                       input logic [4:0] irs, input logic [4:0] irt,
                       input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                       input logic fl);
    issue_valid    = iv;
    issue_regwrite = irw;
    issue_dest     = idest;
    rs             = irs;
    rt             = irt;
    RegWrite       = rw;
    write_register = wr;
    write_data     = wd;
    flush          = fl;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic st, input logic sbe);
    exp_t e;
    e.tag = tag;
    e.rd1 = rd1;
    e.rd2 = rd2;
    e.st  = st;
    e.sbe = sbe;
    exp_q.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp32({e.tag, ".rd1"}, read_data1, e.rd1);
      cmp32({e.tag, ".rd2"}, read_data2, e.rd2);
      cmp1({e.tag, ".stall"}, stall, e.st);
      cmp1({e.tag, ".sb_error"}, sb_error, e.sbe);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    rst = 1'b1;
    #2;
    expect_out("reset_init", 32'h0, 32'h0, 0, 0);
    check_out();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Write-through: give reg 5 a pending entry first so the commit is legal.
    drive(1, 1, 5, 0, 0, 0, 0, 32'h0, 0);
    expect_out("issue5", 32'h0, 32'h0, 0, 0);
    check_out(); tick();
    drive(0, 0, 0, 5, 5, 1, 5, 32'hDEADBEEF, 0);
    expect_out("wthru5", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    check_out(); tick();
    drive(1, 0, 0, 5, 0, 0, 0, 32'h0, 0);
    expect_out("held5", 32'hDEADBEEF, 32'h0, 0, 0);
    check_out(); tick();

    // Register 0: write discarded, issue to dest 0 neither counts nor stalls.
    drive(1, 1, 0, 0, 5, 1, 0, 32'h1234, 0);
    expect_out("reg0_wr", 32'h0, 32'hDEADBEEF, 0, 0);
    check_out(); tick();
    drive(1, 1, 0, 0, 0, 0, 0, 32'h0, 0);
    expect_out("reg0_rd", 32'h0, 32'h0, 0, 0);
    check_out(); tick();

    // Load-use on rs.
    drive(1, 1, 8, 0, 0, 0, 0, 32'h0, 0);
    expect_out("issue8", 32'h0, 32'h0, 0, 0);
    check_out(); tick();
    drive(1, 0, 0, 8, 0, 0, 0, 32'h0, 0);
    expect_out("lu_stall_a", 32'h0, 32'h0, 1, 0);
    check_out(); tick();
    expect_out("lu_stall_b", 32'h0, 32'h0, 1, 0);
    check_out(); tick();
    drive(1, 0, 0, 8, 0, 1, 8, 32'hCAFEF00D, 0);
    expect_out("lu_wb", 32'hCAFEF00D, 32'h0, 0, 0);
    check_out(); tick();
    drive(1, 0, 0, 8, 8, 0, 0, 32'h0, 0);
    expect_out("lu_after", 32'hCAFEF00D, 32'hCAFEF00D, 0, 0);
    check_out(); tick();

    // Hazard on rt.
    drive(1, 1, 10, 0, 0, 0, 0, 32'h0, 0);
    expect_out("issue10", 32'h0, 32'h0, 0, 0);
    check_out(); tick();
    drive(1, 0, 0, 0, 10, 0, 0, 32'h0, 0);
    expect_out("rt_stall", 32'h0, 32'h0, 1, 0);
    check_out(); tick();

    // Flush with pend[9]=2, a simultaneous issue to 9 and an unscoreboarded commit to 4.
    drive(1, 1, 9, 0, 0, 0, 0, 32'h0, 0);
    expect_out("issue9_a", 32'h0, 32'h0, 0, 0);
    check_out(); tick();
    expect_out("issue9_b", 32'h0, 32'h0, 0, 0);
    check_out(); tick();
    drive(1, 1, 9, 9, 0, 1, 4, 32'h44444444, 1);
    expect_out("flush", 32'h0, 32'h0, 0, 0);
    check_out(); tick();
    drive(1, 0, 0, 9, 10, 0, 0, 32'h0, 0);
    expect_out("post_flush", 32'h0, 32'h0, 0, 0);
    check_out(); tick();
    drive(1, 0, 0, 9, 4, 0, 0, 32'h0, 0);
    expect_out("flush_commit", 32'h0, 32'h44444444, 0, 0);
    check_out(); tick();

    // Saturation on reg 3, then drain and one surplus commit.
    drive(1, 1, 3, 0, 0, 0, 0, 32'h0, 0);
    expect_out("sat_i1", 32'h0, 32'h0, 0, 0);
    check_out(); tick();
    expect_out("sat_i2", 32'h0, 32'h0, 0, 0);
    check_out(); tick();
    expect_out("sat_i3", 32'h0, 32'h0, 0, 0);
    check_out(); tick();
    expect_out("sat_i4", 32'h0, 32'h0, 1, 0);
    check_out(); tick();
    drive(1, 0, 0, 3, 0, 1, 3, 32'h11, 0);
    expect_out("drain1", 32'h11, 32'h0, 1, 0);
    check_out(); tick();
    drive(1, 0, 0, 3, 0, 1, 3, 32'h22, 0);
    expect_out("drain2", 32'h22, 32'h0, 1, 0);
    check_out(); tick();
    drive(1, 0, 0, 3, 0, 1, 3, 32'h33, 0);
    expect_out("drain3", 32'h33, 32'h0, 0, 0);
    check_out(); tick();
    drive(0, 0, 0, 3, 0, 1, 3, 32'h44, 0);
    expect_out("surplus_wb", 32'h44, 32'h0, 0, 0);
    check_out(); tick();
    drive(0, 0, 0, 3, 0, 0, 0, 32'h0, 0);
    expect_out("sb_err_set", 32'h44, 32'h0, 0, 1);
    check_out(); tick();
    expect_out("sb_err_sticky", 32'h44, 32'h0, 0, 1);
    check_out(); tick();

    // Asynchronous reset mid-run with a live hazard on reg 12.
    drive(1, 1, 12, 0, 0, 0, 0, 32'h0, 0);
    expect_out("issue12", 32'h0, 32'h0, 0, 1);
    check_out(); tick();
    drive(1, 0, 0, 12, 5, 0, 0, 32'h0, 0);
    expect_out("pre_rst", 32'h0, 32'hDEADBEEF, 1, 1);
    check_out();
    rst = 1'b1;
    expect_out("async_rst", 32'h0, 32'h0, 0, 0);
    check_out();
    tick(); tick();
    rst = 1'b0;
    drive(1, 0, 0, 12, 5, 0, 0, 32'h0, 0);
    expect_out("post_rst", 32'h0, 32'h0, 0, 0);
    check_out(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
